// File: rtl/spi_cap_pkg.sv
// Shared types for the SPI word capture monitor: FIFO entry payload and FSM states.
package spi_cap_pkg;

  localparam int unsigned CAP_MAX_W   = 32;
  localparam int unsigned CAP_NBITS_W = $clog2(CAP_MAX_W + 1);

  // One captured word as stored in the FIFO; narrower words are zero-extended.
  typedef struct packed {
    logic [CAP_MAX_W-1:0]   word;
    logic                   dc;
    logic                   partial;
    logic [CAP_NBITS_W-1:0] nbits;
  } cap_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } cap_state_e;

endpackage

// File: rtl/spi_cap_fifo.sv
// Show-ahead FIFO of captured words; wrap-around pointers with an extra MSB,
// registered level/full/empty flags.
module spi_cap_fifo
  import spi_cap_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         spi_sclk,
  input  logic                         resetn,
  input  logic                         i_clr,
  input  logic                         i_push,
  input  cap_entry_t                   i_data,
  input  logic                         i_pop,
  output cap_entry_t                   o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  cap_entry_t         r_mem [DEPTH];
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_full;
  logic               r_empty;

  logic               w_do_pop;
  logic               w_do_push;
  logic [PW-1:0]      w_wptr_nxt;
  logic [PW-1:0]      w_rptr_nxt;

  // A pop frees the head slot in the same edge, so a full FIFO still accepts a push.
  assign w_do_pop   = i_pop && !r_empty;
  assign w_do_push  = i_push && (!r_full || w_do_pop);
  assign w_wptr_nxt = r_wptr + PW'(w_do_push);
  assign w_rptr_nxt = r_rptr + PW'(w_do_pop);

  always_ff @(posedge spi_sclk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_level <= LVL_W'(w_wptr_nxt - w_rptr_nxt);
      r_empty <= (w_wptr_nxt == w_rptr_nxt);
      r_full  <= (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                 (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge spi_sclk) begin
    if (w_do_push && !i_clr) begin
      r_mem[r_wptr[AW-1:0]] <= i_data;
    end
  end

  assign o_head  = r_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign o_level = r_level;
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/spi_word_capture.sv
// SPI receive monitor: shifts csn-framed serial data into WORD_W-bit words tagged
// with dc, flags truncated words, and queues them with overflow/frame statistics.
module spi_word_capture
  import spi_cap_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                          spi_sclk,
  input  logic                          resetn,
  input  logic                          clr,
  input  logic                          csn,
  input  logic                          spi_sdo,
  input  logic                          dc,
  input  logic                          rd_en,
  output logic                          rd_valid,
  output logic [WORD_W-1:0]             rd_word,
  output logic                          rd_dc,
  output logic                          rd_partial,
  output logic [$clog2(WORD_W+1)-1:0]   rd_nbits,
  output logic [$clog2(DEPTH+1)-1:0]    level,
  output logic                          overflow,
  output logic [15:0]                   drop_count,
  output logic [31:0]                   word_total,
  output logic [15:0]                   frame_count
);

  localparam int unsigned NB_W = $clog2(WORD_W + 1);

  cap_state_e          r_state;
  logic [NB_W-1:0]     r_bit_cnt;
  logic [WORD_W-1:0]   r_shift;
  logic                r_word_dc;
  logic                r_overflow;
  logic [15:0]         r_drop_count;
  logic [31:0]         r_word_total;
  logic [15:0]         r_frame_count;

  logic [NB_W-1:0]     w_pos;
  logic [WORD_W-1:0]   w_shift_nxt;
  logic                w_first;
  logic                w_last;
  logic                w_push_full;
  logic                w_push_part;
  logic                w_push;
  logic                w_drop;
  logic                w_full;
  logic                w_empty;
  logic                w_unused_head;
  cap_entry_t          w_push_entry;
  cap_entry_t          w_head;

  assign w_first     = (r_state == IDLE) || (r_bit_cnt == '0);
  assign w_last      = (r_state == SHIFT) && (r_bit_cnt == NB_W'(WORD_W - 1));
  assign w_pos       = MSB_FIRST ? (NB_W'(WORD_W - 1) - r_bit_cnt) : r_bit_cnt;
  assign w_shift_nxt = r_shift | (WORD_W'(spi_sdo) << w_pos);

  // Full word completes on the edge sampling its last bit; a truncated one on csn rising.
  assign w_push_full = !csn && w_last;
  assign w_push_part = csn && (r_state == SHIFT) && (r_bit_cnt != '0);
  assign w_push      = w_push_full || w_push_part;
  assign w_drop      = w_push && w_full && !rd_en;

  always_comb begin
    w_push_entry         = '0;
    w_push_entry.word    = CAP_MAX_W'(w_push_full ? w_shift_nxt : r_shift);
    w_push_entry.dc      = r_word_dc;
    w_push_entry.partial = w_push_part;
    w_push_entry.nbits   = w_push_full ? CAP_NBITS_W'(WORD_W) : CAP_NBITS_W'(r_bit_cnt);
  end

  // Frame FSM and shifter
  always_ff @(posedge spi_sclk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_word_dc <= 1'b0;
    end else if (clr) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_word_dc <= 1'b0;
    end else if (!csn) begin
      r_state <= SHIFT;
      if (w_first) begin
        r_word_dc <= dc;
      end
      if (w_last) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else begin
        r_shift   <= w_shift_nxt;
        r_bit_cnt <= NB_W'(r_bit_cnt + 1'b1);
      end
    end else begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end
  end

  // Statistics
  always_ff @(posedge spi_sclk or negedge resetn) begin
    if (!resetn) begin
      r_overflow    <= 1'b0;
      r_drop_count  <= '0;
      r_word_total  <= '0;
      r_frame_count <= '0;
    end else if (clr) begin
      r_overflow    <= 1'b0;
      r_drop_count  <= '0;
      r_word_total  <= '0;
      r_frame_count <= '0;
    end else begin
      if (w_push) begin
        r_word_total <= r_word_total + 32'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) begin
          r_drop_count <= r_drop_count + 16'd1;
        end
      end
      if (csn && (r_state == SHIFT)) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  spi_cap_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .spi_sclk (spi_sclk),
    .resetn   (resetn),
    .i_clr    (clr),
    .i_push   (w_push),
    .i_data   (w_push_entry),
    .i_pop    (rd_en),
    .o_head   (w_head),
    .o_level  (level),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign rd_valid      = !w_empty;
  assign rd_word       = w_head.word[WORD_W-1:0];
  assign rd_dc         = w_head.dc;
  assign rd_partial    = w_head.partial;
  assign rd_nbits      = w_head.nbits[NB_W-1:0];
  assign w_unused_head = ^{w_head.word, w_head.nbits};

  assign overflow    = r_overflow;
  assign drop_count  = r_drop_count;
  assign word_total  = r_word_total;
  assign frame_count = r_frame_count;

endmodule

// File: doc/spi_word_capture.md
# spi_word_capture

Parametrised SPI receive monitor for the display link (spi_sclk/spi_sdo/dc/csn) driven by the SoC when built with SPI_OUTPUT. It generalises the fixed 32-bit MSB-first capture register into configurable word width and bit order. Each word is tagged with its dc (command/data) level, and truncated transfers are flagged. Captured words are buffered in a show-ahead FIFO with occupancy, overflow and frame statistics, so benches and scoreboards can pop complete display commands and pixels instead of sampling one shared register.

## Interface
- WORD_W, 32: bits per captured word, 8..32.
- DEPTH, 16: FIFO entries, power of two, 2..256.
- MSB_FIRST, 1: 1 = first bit lands in bit WORD_W-1; 0 = first bit lands in bit 0.

- spi_sclk  in  1  capture clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear; same effect as reset.
- csn  in  1  chip select, active low, sampled on spi_sclk.
- spi_sdo  in  1  serial data, sampled on spi_sclk.
- dc  in  1  data/command select, sampled on spi_sclk.
- rd_en  in  1  pop head entry; ignored when rd_valid=0.
- rd_valid  out  1  FIFO not empty.
- rd_word  out  WORD_W  head word; zero when empty.
- rd_dc  out  1  dc sampled on the first bit of the head word.
- rd_partial  out  1  head word ended by csn deassertion before WORD_W bits.
- rd_nbits  out  $clog2(WORD_W+1)  bits actually received for the head word.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.
- overflow  out  1  sticky; set when a push is dropped.
- drop_count  out  16  dropped words, saturating at 16'hFFFF.
- word_total  out  32  words pushed, including partial words; wraps.
- frame_count  out  16  completed csn-low frames; wraps.

## Operation
- FSM states:
  - IDLE: csn high last edge.
  - SHIFT: csn low, mid-word.
- IDLE transitions:
  - csn=0: sample bit 0 of a word, capture dc into word_dc, go to SHIFT, or stay in IDLE for another new word when WORD_W=1. WORD_W=1 is excluded by the parameter range.
  - csn=1: no action.
- SHIFT, csn=0:
  - Store spi_sdo at position bit_cnt: WORD_W-1-bit_cnt when MSB_FIRST, else bit_cnt.
  - Increment bit_cnt.
  - At bit_cnt==WORD_W-1: push {word, word_dc, partial=0, nbits=WORD_W}, clear the shift register and bit_cnt, stay in SHIFT. The next bit starts a new word and captures a new word_dc.
- Word-boundary dc tracking: when bit_cnt==0 in SHIFT, the bit is the first of a word and dc is captured.
- Any state, csn=1 after csn was low:
  - Increment frame_count.
  - If bit_cnt!=0, push {word, word_dc, partial=1, nbits=bit_cnt}. Unreceived bit positions read 0.
  - Go to IDLE.
- Frame end is detected only on a spi_sclk edge with csn high. Without such an edge, the frame stays open.
- Push into a full FIFO, no pop that edge: drop the entry, set overflow, increment drop_count, still increment word_total.
- Push and pop on the same edge when full: both occur, level unchanged, no drop.
- Push and pop on the same edge when empty: the push is stored; the pop is ignored.
- rd_en with rd_valid=0: no effect, no error.
- rd_dc, rd_partial and rd_nbits are 0 when empty.

## Timing
- Reset or clr: FSM=IDLE, bit_cnt=0, shift register 0, FIFO empty. rd_valid=0, rd_word=0, rd_dc=0, rd_partial=0, rd_nbits=0, level=0, overflow=0, drop_count=0, word_total=0, frame_count=0.
- Reset asserted mid-word discards the partial word without pushing it.
- Latency: the edge sampling the last bit of a word also performs the push. rd_valid and level update immediately after that edge. Data is visible 0 cycles after the edge, readable on the next edge.
- Head is show-ahead: rd_word and its flags are valid whenever rd_valid=1. A pop presents the next entry after the popping edge.
- Counters are registered and update on the same edge as the causing event.
- All outputs are registered, or a mux from registered storage.

## Structure
- Package spi_cap_pkg holds:
  - typedef cap_entry_t: word, dc, partial, nbits, parametrised via a localparam max width of 32.
  - typedef enum cap_state_e {IDLE, SHIFT}.
- Sub-module spi_cap_fifo: synchronous show-ahead FIFO of cap_entry_t, DEPTH entries. Pointers are wrap-around with an extra MSB for full/empty. Push/pop/level/full/empty ports only.
- Top level holds the FSM, shifter, bit counter and statistics counters.

## Test plan
- WORD_W=32, MSB_FIRST=1, dc=1: send 32'hA5C3_0F96 in one frame, then csn high for 1 edge. Expect rd_word=32'hA5C3_0F96, rd_dc=1, rd_partial=0, rd_nbits=32, frame_count=1.
- WORD_W=8, MSB_FIRST=0: send bytes 8'h2A then 8'h81 back-to-back, dc=0 then 1, LSB first. Expect two entries in order (8'h2A, dc 0) and (8'h81, dc 1), word_total=2.
- WORD_W=16: send 5 bits 1,0,1,1,1 MSB-first, then raise csn for one edge. Expect rd_word=16'hB800, rd_partial=1, rd_nbits=5.
- DEPTH=4: push 6 words without popping. Expect level=4, overflow=1, drop_count=2, word_total=6, and the first 4 words retained in order.
- Full FIFO, rd_en=1 on the edge completing a word. Expect level stays 4, overflow unchanged, and the popped word is replaced at the tail.
- Assert resetn=0 after 10 bits of a word, then release. Expect all outputs at reset values and the next 32 bits captured as a clean word.
